cv32e40x_rvfi_trace_buffer: RTL and testbench

//  Synthesizable, parametrised retirement-trace capture for the RVFI interface, with NRET retire channels.

---
 rtl/cv32e40x_rvfi_trace_buffer.sv | 205 ++++++++++++++++++++
 tb/tb_cv32e40x_rvfi_trace_buffer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_rvfi_trace_buffer.sv
// RVFI retirement-trace capture buffer.
// Each retired instruction is packed into a 145-bit timestamped record and
// pushed into a DEPTH-entry FIFO drained by a valid/ready reader. Capture is
// gated by an IDLE/ARMED/CAPTURE/DONE state machine with optional PC start and
// stop triggers, and a drop-or-freeze policy when the FIFO has no free slot.

package cv32e40x_rvfi_pkg;
    parameter int NMEM = 2;
endpackage

module cv32e40x_rvfi_trace_buffer #(
    parameter int NRET  = 1,
    parameter int DEPTH = 8,
    parameter int NMEM  = cv32e40x_rvfi_pkg::NMEM
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cfg_en_i,
    input  logic                         cfg_freeze_i,
    input  logic                         cfg_trig_en_i,
    input  logic [31:0]                  trig_start_pc_i,
    input  logic [31:0]                  trig_stop_pc_i,
    input  logic [NRET-1:0]              rvfi_valid,
    input  logic [32*NRET-1:0]           rvfi_pc_rdata,
    input  logic [5*NRET-1:0]            rvfi_rd_addr,
    input  logic [32*NRET-1:0]           rvfi_rd_wdata,
    input  logic [32*NMEM*NRET-1:0]      rvfi_mem_addr,
    input  logic [4*NMEM*NRET-1:0]       rvfi_mem_rmask,
    input  logic [4*NMEM*NRET-1:0]       rvfi_mem_wmask,
    output logic                         rd_valid_o,
    input  logic                         rd_ready_i,
    output logic [144:0]                 rd_data_o,
    output logic [$clog2(DEPTH):0]       level_o,
    output logic [15:0]                  drop_cnt_o,
    output logic [1:0]                   state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = 145;
    localparam int DW = $clog2(NRET + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      wptr_q, wptr_d;
    logic [AW-1:0]      rptr_q, rptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [15:0]        drop_q, drop_d;
    logic [31:0]        ts_q;
    logic [RW-1:0]      mem_q [DEPTH];

    logic [RW-1:0]      rec [NRET];
    logic [AW-1:0]      wr_idx [NRET];
    logic [NRET-1:0]    push_en;
    logic [LW-1:0]      free;
    logic [LW-1:0]      used;
    logic [DW-1:0]      drop_n;
    logic               capturing;
    logic               halt;
    logic               pop;

    // First active memop (address and masks) plus saturating count of active memops.
    function automatic logic [43:0] mem_summary(input logic [32*NMEM-1:0] addr,
                                                input logic [4*NMEM-1:0]  rmask,
                                                input logic [4*NMEM-1:0]  wmask);
        logic [31:0] a;
        logic [3:0]  r;
        logic [3:0]  w;
        logic [3:0]  n;
        logic        found;
        a     = '0;
        r     = '0;
        w     = '0;
        n     = '0;
        found = 1'b0;
        for (int m = 0; m < NMEM; m++) begin
            if ((rmask[m*4 +: 4] | wmask[m*4 +: 4]) != 4'd0) begin
                if (!found) begin
                    a     = addr[m*32 +: 32];
                    r     = rmask[m*4 +: 4];
                    w     = wmask[m*4 +: 4];
                    found = 1'b1;
                end
                if (n != 4'hF) begin
                    n = n + 4'd1;
                end
            end
        end
        return {a, r, w, n};
    endfunction

    // Saturating add for the drop counter.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [DW-1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign rd_valid_o = (level_q != '0);
    assign rd_data_o  = rd_valid_o ? mem_q[rptr_q] : '0;
    assign level_o    = level_q;
    assign drop_cnt_o = drop_q;
    assign state_o    = state_q;
    assign pop        = rd_valid_o && rd_ready_i;
    // A same-cycle pop never frees a slot for this cycle's pushes.
    assign free       = LW'(DEPTH) - level_q;

    // Pack one record per retire channel, stamped with this cycle's timestamp.
    always_comb begin
        for (int i = 0; i < NRET; i++) begin
            rec[i] = {ts_q,
                      rvfi_pc_rdata[i*32 +: 32],
                      rvfi_rd_addr[i*5 +: 5],
                      rvfi_rd_wdata[i*32 +: 32],
                      mem_summary(rvfi_mem_addr[i*32*NMEM +: 32*NMEM],
                                  rvfi_mem_rmask[i*4*NMEM +: 4*NMEM],
                                  rvfi_mem_wmask[i*4*NMEM +: 4*NMEM])};
        end
    end

    // Next state, slot allocation in program order, drops and trigger handling.
    always_comb begin
        state_d   = state_q;
        push_en   = '0;
        drop_n    = '0;
        used      = '0;
        capturing = (state_q == ST_CAPTURE);
        halt      = 1'b0;
        for (int i = 0; i < NRET; i++) begin
            wr_idx[i] = wptr_q + used[AW-1:0];
            if (rvfi_valid[i] && !halt && (state_q == ST_ARMED || state_q == ST_CAPTURE)) begin
                // The start match opens capture for this channel and all younger ones.
                if (state_q == ST_ARMED && !capturing &&
                    rvfi_pc_rdata[i*32 +: 32] == trig_start_pc_i) begin
                    capturing = 1'b1;
                end
                if (capturing) begin
                    if (used < free) begin
                        push_en[i] = 1'b1;
                        used       = used + LW'(1);
                    end else begin
                        drop_n = drop_n + DW'(1);
                        if (cfg_freeze_i) begin
                            halt    = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                    // Stop record itself is kept; younger same-cycle retirements are not.
                    if (rvfi_pc_rdata[i*32 +: 32] == trig_stop_pc_i) begin
                        halt    = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
        end
        if (state_q == ST_ARMED && capturing && !halt) begin
            state_d = ST_CAPTURE;
        end
        if (state_q == ST_IDLE) begin
            state_d = cfg_trig_en_i ? ST_ARMED : ST_CAPTURE;
        end
        if (!cfg_en_i) begin
            state_d = ST_IDLE;
        end
        wptr_d  = wptr_q + used[AW-1:0];
        rptr_d  = rptr_q + AW'(pop);
        level_d = level_q + used - LW'(pop);
        drop_d  = sat_add16(drop_q, drop_n);
    end

    // Control state, pointers, occupancy, drop counter and free-running timestamp.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            drop_q  <= '0;
            ts_q    <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            drop_q  <= drop_d;
            ts_q    <= ts_q + 32'd1;
        end
    end

    // Record storage; contents are only meaningful below the occupancy level.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NRET; i++) begin
            if (push_en[i]) begin
                mem_q[wr_idx[i]] <= rec[i];
            end
        end
    end

endmodule

// File: tb/tb_cv32e40x_rvfi_trace_buffer.sv
// Scoreboard bench for the RVFI trace buffer: directed scenarios followed by
// randomized retirement traffic checked against a rule-level reference model.
module tb_cv32e40x_rvfi_trace_buffer;

    localparam int NRET  = 2;
    localparam int DEPTH = 4;
    localparam int NMEM  = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    en = 1'b0;
    logic                    frz = 1'b0;
    logic                    trg = 1'b0;
    logic [31:0]             start_pc = 32'h200;
    logic [31:0]             stop_pc = 32'hFFFF_FFF0;
    logic [NRET-1:0]         valid = '0;
    logic [32*NRET-1:0]      pc_v = '0;
    logic [5*NRET-1:0]       rd_v = '0;
    logic [32*NRET-1:0]      wd_v = '0;
    logic [32*NMEM*NRET-1:0] ma_v = '0;
    logic [4*NMEM*NRET-1:0]  rm_v = '0;
    logic [4*NMEM*NRET-1:0]  wm_v = '0;
    logic                    ready = 1'b0;

    logic                    rd_valid_o;
    logic [144:0]            rd_data_o;
    logic [LW-1:0]           level_o;
    logic [15:0]             drop_cnt_o;
    logic [1:0]              state_o;

    int             checks = 0;
    int             failures = 0;
    int             m_level = 0;
    int             m_state = 0;
    int             m_drop = 0;
    logic [31:0]    m_ts = '0;
    logic [144:0]   exp_q[$];

    cv32e40x_rvfi_trace_buffer #(.NRET(NRET), .DEPTH(DEPTH), .NMEM(NMEM)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cfg_en_i        (en),
        .cfg_freeze_i    (frz),
        .cfg_trig_en_i   (trg),
        .trig_start_pc_i (start_pc),
        .trig_stop_pc_i  (stop_pc),
        .rvfi_valid      (valid),
        .rvfi_pc_rdata   (pc_v),
        .rvfi_rd_addr    (rd_v),
        .rvfi_rd_wdata   (wd_v),
        .rvfi_mem_addr   (ma_v),
        .rvfi_mem_rmask  (rm_v),
        .rvfi_mem_wmask  (wm_v),
        .rd_valid_o      (rd_valid_o),
        .rd_ready_i      (ready),
        .rd_data_o       (rd_data_o),
        .level_o         (level_o),
        .drop_cnt_o      (drop_cnt_o),
        .state_o         (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Expected record for a channel: summary of the first active memop, count of active memops.
    function automatic logic [144:0] model_rec(input int ch);
        logic [31:0] a;
        logic [3:0]  r;
        logic [3:0]  w;
        logic [3:0]  rr;
        logic [3:0]  ww;
        int          n;
        a  = '0;
        rr = '0;
        ww = '0;
        n  = 0;
        for (int m = 0; m < NMEM; m++) begin
            r = rm_v[(ch*NMEM+m)*4 +: 4];
            w = wm_v[(ch*NMEM+m)*4 +: 4];
            if (r != 4'd0 || w != 4'd0) begin
                if (n == 0) begin
                    a  = ma_v[(ch*NMEM+m)*32 +: 32];
                    rr = r;
                    ww = w;
                end
                n++;
            end
        end
        if (n > 15) n = 15;
        return {m_ts, pc_v[ch*32 +: 32], rd_v[ch*5 +: 5], wd_v[ch*32 +: 32], a, rr, ww, 4'(n)};
    endfunction

    task automatic set_ch(input int ch, input logic [31:0] pc);
        valid[ch]          = 1'b1;
        pc_v[ch*32 +: 32]  = pc;
        rd_v[ch*5 +: 5]    = 5'($urandom);
        wd_v[ch*32 +: 32]  = $urandom;
        for (int m = 0; m < NMEM; m++) begin
            ma_v[(ch*NMEM+m)*32 +: 32] = $urandom;
            if ($urandom_range(1, 0) == 1) begin
                rm_v[(ch*NMEM+m)*4 +: 4] = 4'($urandom);
                wm_v[(ch*NMEM+m)*4 +: 4] = 4'($urandom);
            end else begin
                rm_v[(ch*NMEM+m)*4 +: 4] = 4'd0;
                wm_v[(ch*NMEM+m)*4 +: 4] = 4'd0;
            end
        end
    endtask

    // Apply the capture rules to this cycle's inputs, advance one clock, check status outputs.
    task automatic cycle();
        int   pushes;
        int   free_slots;
        int   nst;
        bit   cap;
        bit   halt;
        bit   pop;
        logic [31:0] p;
        if (!rst) begin
            pop        = (m_level > 0) && ready;
            free_slots = DEPTH - m_level;
            pushes     = 0;
            cap        = (m_state == 2);
            halt       = 0;
            nst        = m_state;
            if (m_state == 1 || m_state == 2) begin
                for (int ch = 0; ch < NRET; ch++) begin
                    if (valid[ch] && !halt) begin
                        p = pc_v[ch*32 +: 32];
                        if (m_state == 1 && !cap && p === start_pc) cap = 1;
                        if (cap) begin
                            if (pushes < free_slots) begin
                                exp_q.push_back(model_rec(ch));
                                pushes++;
                            end else begin
                                if (m_drop < 65535) m_drop++;
                                if (frz) begin
                                    halt = 1;
                                    nst  = 3;
                                end
                            end
                            if (p === stop_pc) begin
                                halt = 1;
                                nst  = 3;
                            end
                        end
                    end
                end
            end
            if (m_state == 1 && cap && !halt) nst = 2;
            if (m_state == 0) nst = trg ? 1 : 2;
            if (!en) nst = 0;
            m_level = m_level + pushes - (pop ? 1 : 0);
            m_state = nst;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_level = 0;
            m_state = 0;
            m_drop  = 0;
            m_ts    = '0;
            exp_q.delete();
        end else begin
            m_ts = m_ts + 32'd1;
        end
        valid = '0;
        chk("level", 64'(level_o), 64'(m_level));
        chk("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
        chk("state", 64'(state_o), 64'(m_state));
        chk("rd_valid", 64'(rd_valid_o), 64'(m_level != 0));
    endtask

    task automatic retire(input logic [31:0] pc);
        set_ch(0, pc);
        cycle();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Scoreboard monitor: every accepted head record must match the oldest expected record.
    initial begin
        logic [144:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && rd_valid_o === 1'b1 && ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rec_unexpected actual=%h required=none", rd_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (rd_data_o !== e) begin
                        failures++;
                        $display("FAIL rec actual=%h required=%h", rd_data_o, e);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] pcs [6];
        logic [15:0] d0;
        pcs[0] = 32'h1FC; pcs[1] = 32'h200; pcs[2] = 32'h204;
        pcs[3] = 32'h20C; pcs[4] = 32'h400; pcs[5] = 32'h404;

        // Reset state
        rst = 1'b1;
        idle(2);
        chk("reset_rd_data", 64'(rd_data_o == '0), 64'd1);
        rst = 1'b0;

        // T1: plain capture with immediate readout, irregular retire gaps
        en = 1'b1; ready = 1'b1;
        idle(1);
        retire(32'h100); idle(2);
        retire(32'h104); idle(1);
        retire(32'h108); idle(1);
        // Unknown PC is stored unchanged
        retire('x); idle(2);

        // T2: drop policy, no reader
        ready = 1'b0;
        for (int k = 0; k < 6; k++) retire(32'h500 + 32'(4*k));
        chk("t2_level", 64'(level_o), 64'd4);
        chk("t2_drop", 64'(drop_cnt_o), 64'd2);
        ready = 1'b1;
        idle(6);

        // T3: freeze policy
        frz = 1'b1; ready = 1'b0;
        for (int k = 0; k < 5; k++) retire(32'h600 + 32'(4*k));
        chk("t3_state", 64'(state_o), 64'd3);
        chk("t3_drop", 64'(drop_cnt_o), 64'd3);
        en = 1'b0;
        idle(1);
        chk("t3_idle", 64'(state_o), 64'd0);
        ready = 1'b1; frz = 1'b0;
        idle(6);

        // T4: start/stop triggers
        trg = 1'b1; stop_pc = 32'h20C; en = 1'b1;
        idle(1);
        for (int k = 0; k < 6; k++) retire(32'h1FC + 32'(4*k));
        chk("t4_state", 64'(state_o), 64'd3);
        idle(3);
        en = 1'b0; idle(1);
        trg = 1'b0; stop_pc = 32'hFFFF_FFF0; en = 1'b1;
        idle(1);

        // T5: dual retire into one free slot; same-cycle pop does not help
        ready = 1'b0;
        for (int k = 0; k < 3; k++) retire(32'h700 + 32'(4*k));
        d0 = drop_cnt_o;
        set_ch(0, 32'h710); set_ch(1, 32'h714);
        ready = 1'b1;
        cycle();
        chk("t5_level", 64'(level_o), 64'd3);
        chk("t5_drop", 64'(drop_cnt_o), 64'(d0 + 16'd1));
        idle(5);

        // T6: store at memop1 only, then reset during a burst
        ready = 1'b0;
        set_ch(0, 32'h800);
        rm_v[7:0] = 8'h00; wm_v[7:0] = 8'hF0; ma_v[63:32] = 32'h1234_5678;
        cycle();
        chk("t6_maddr", 64'(rd_data_o[43:12]), 64'h1234_5678);
        chk("t6_rmask", 64'(rd_data_o[11:8]), 64'h0);
        chk("t6_wmask", 64'(rd_data_o[7:4]), 64'hF);
        chk("t6_nmemop", 64'(rd_data_o[3:0]), 64'h1);
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
        retire(32'h804); retire(32'h808);
        set_ch(0, 32'h80C); set_ch(1, 32'h810);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t6_level", 64'(level_o), 64'd0);
        chk("t6_state", 64'(state_o), 64'd0);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(39, 0) == 0) en = ~en;
            if ($urandom_range(49, 0) == 0) begin
                trg = 1'($urandom);
                frz = 1'($urandom);
                stop_pc = ($urandom_range(1, 0) == 1) ? 32'h20C : 32'hFFFF_FFF0;
            end
            ready = ($urandom_range(2, 0) != 0);
            for (int ch = 0; ch < NRET; ch++) begin
                if ($urandom_range(1, 0) == 1) set_ch(ch, pcs[$urandom_range(5, 0)]);
            end
            rst = ($urandom_range(199, 0) == 0);
            cycle();
            rst = 1'b0;
        end

        // Drain whatever remains
        valid = '0; ready = 1'b1;
        for (int k = 0; k < 20 && m_level > 0; k++) cycle();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
